wdg_timer: RTL and testbench

Watchdog timer on the always-on clk_osc domain that produces the reset_wdg request consumed by the chip reset generator. Software arms it through a small key-protected register write port. A missed kick first raises an interrupt. A second consecutive timeout issues a fixed-length reset_wdg pulse, which the reset generator double-syncs and turns into a full system reset. Because the block sits on rst_ext_n, its configuration survives the watchdog reset it causes.

---
 rtl/wdg_timer.sv | 205 ++++++++++++++++++++
 tb/tb_wdg_timer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdg_timer.sv
// Key-protected watchdog on the always-on clk_osc domain: interrupt on first timeout, reset_wdg pulse on second.
// Optional kick window (WIN register, CTRL[2]) is built only when WDG_WINDOW_EN is defined.
module wdg_timer #(
    parameter int          CNT_W      = 24,
    parameter logic [15:0] KICK_KEY   = 16'hA55A,
    parameter logic [15:0] UNLOCK_KEY = 16'h1ACC,
    parameter int          RST_PULSE  = 4
) (
    input  logic             clk_osc,
    input  logic             rst_ext_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             dbg_halt,
    output logic             wdg_irq,
    output logic             reset_wdg,
    output logic [CNT_W-1:0] cnt_val,
    output logic [1:0]       wdg_sts
);

    localparam int PC_W = (RST_PULSE > 2) ? $clog2(RST_PULSE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_IRQ,
        ST_RST
    } state_t;

    state_t            state;
    logic              en;
    logic              rst_en;
    logic              unlock;
    logic [CNT_W-1:0]  load;
    logic [CNT_W-1:0]  counter;
    logic [PC_W-1:0]   pulse_cnt;

    logic              key_wr;
    logic              key_unlock;
    logic              key_kick;
    logic              key_bad;
    logic              ctrl_wr;
    logic              load_wr;
    logic              win_wr;
    logic              reg_wr;
    logic              early_kick;
    logic              kick;
    logic              violation;
    logic [CNT_W-1:0]  load_eff;
    logic              unused_wr_data;

    assign unused_wr_data = ^wr_data;

`ifdef WDG_WINDOW_EN
    logic              win_en;
    logic [CNT_W-1:0]  win;
`endif

    always_comb begin
        key_wr     = wr_en && (wr_addr == 2'd3);
        key_unlock = key_wr && (wr_data[15:0] == UNLOCK_KEY);
        key_kick   = key_wr && (wr_data[15:0] == KICK_KEY);
        key_bad    = key_wr && !key_unlock && !key_kick;
        // CTRL is frozen for the duration of a reset pulse
        ctrl_wr    = wr_en && (wr_addr == 2'd0) && unlock && (state != ST_RST);
        load_wr    = wr_en && (wr_addr == 2'd1) && unlock;
`ifdef WDG_WINDOW_EN
        win_wr     = wr_en && (wr_addr == 2'd2) && unlock;
        early_kick = key_kick && (state == ST_RUN) && win_en && (counter > win);
`else
        win_wr     = 1'b0;
        early_kick = 1'b0;
`endif
        reg_wr     = ctrl_wr || load_wr || win_wr;
        kick       = key_kick && !early_kick && (state != ST_RST);
        violation  = en && (key_bad || early_kick);
        load_eff   = (load == '0) ? CNT_W'(1) : load;
    end

    always_ff @(posedge clk_osc or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            state     <= ST_IDLE;
            en        <= 1'b0;
            rst_en    <= 1'b0;
            unlock    <= 1'b0;
            load      <= '1;
            counter   <= '1;
            pulse_cnt <= '0;
            wdg_irq   <= 1'b0;
            reset_wdg <= 1'b0;
            wdg_sts   <= 2'b00;
`ifdef WDG_WINDOW_EN
            win_en    <= 1'b0;
            win       <= '0;
`endif
        end else begin
            if (reg_wr) begin
                unlock <= 1'b0;
            end else if (key_unlock) begin
                unlock <= 1'b1;
            end

            if (ctrl_wr) begin
                en      <= wr_data[0];
                rst_en  <= wr_data[1];
                wdg_sts <= 2'b00;
            end
            if (load_wr) begin
                load <= wr_data[CNT_W-1:0];
            end
`ifdef WDG_WINDOW_EN
            if (ctrl_wr) begin
                win_en <= wr_data[2];
            end
            if (win_wr) begin
                win <= wr_data[CNT_W-1:0];
            end
`endif
            // Sticky flags set after the CTRL clear so a same-cycle event is never lost
            if (key_bad || early_kick) begin
                wdg_sts[1] <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    counter   <= load_eff;
                    wdg_irq   <= 1'b0;
                    reset_wdg <= 1'b0;
                    if (en) begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        wdg_irq <= 1'b0;
                    end else if (kick) begin
                        counter <= load_eff;
                    end else if (violation) begin
                        state   <= ST_IRQ;
                        wdg_irq <= 1'b1;
                        counter <= load_eff;
                    end else if (!dbg_halt) begin
                        if (counter == '0) begin
                            state      <= ST_IRQ;
                            wdg_irq    <= 1'b1;
                            wdg_sts[0] <= 1'b1;
                            counter    <= load_eff;
                        end else begin
                            counter <= counter - CNT_W'(1);
                        end
                    end
                end

                ST_IRQ: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        wdg_irq <= 1'b0;
                    end else if (kick) begin
                        state   <= ST_RUN;
                        wdg_irq <= 1'b0;
                        counter <= load_eff;
                    end else if (violation) begin
                        if (rst_en) begin
                            state     <= ST_RST;
                            reset_wdg <= 1'b1;
                            pulse_cnt <= PC_W'(RST_PULSE - 1);
                        end
                    end else if (!dbg_halt) begin
                        if (counter == '0) begin
                            wdg_sts[0] <= 1'b1;
                            if (rst_en) begin
                                state     <= ST_RST;
                                reset_wdg <= 1'b1;
                                pulse_cnt <= PC_W'(RST_PULSE - 1);
                            end
                        end else begin
                            counter <= counter - CNT_W'(1);
                        end
                    end
                end

                ST_RST: begin
                    // The pulse length is fixed so the reset generator always sees a full request
                    if (pulse_cnt == '0) begin
                        state     <= ST_RUN;
                        reset_wdg <= 1'b0;
                        wdg_irq   <= 1'b0;
                        counter   <= load_eff;
                    end else begin
                        pulse_cnt <= pulse_cnt - PC_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cnt_val = counter;

endmodule

// File: tb/tb_wdg_timer.sv
// Directed testbench for wdg_timer: lock, expiry, kick, bad-key, debug-halt and window scenarios.
// The window scenario is built when WDG_WINDOW_EN is defined; otherwise the WIN-absent behaviour is checked.
`timescale 1ns/1ps
module tb_wdg_timer;

    localparam logic [31:0] KICK = 32'h0000_A55A;
    localparam logic [31:0] UNLK = 32'h0000_1ACC;
    localparam logic [31:0] BAD  = 32'h0000_1234;

    logic        clk_osc = 1'b0;
    logic        rst_ext_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic        dbg_halt = 1'b0;
    logic        wdg_irq;
    logic        reset_wdg;
    logic [23:0] cnt_val;
    logic [1:0]  wdg_sts;

    int errors = 0;
    int checks = 0;

    wdg_timer dut (
        .clk_osc   (clk_osc),
        .rst_ext_n (rst_ext_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_halt  (dbg_halt),
        .wdg_irq   (wdg_irq),
        .reset_wdg (reset_wdg),
        .cnt_val   (cnt_val),
        .wdg_sts   (wdg_sts)
    );

    always #31.25 clk_osc = ~clk_osc;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_osc);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
        $display("write addr=%0d data=0x%08h -> cnt=%0d irq=%0b rst=%0b sts=%02b",
                 a, d, cnt_val, wdg_irq, reset_wdg, wdg_sts);
    endtask

    task automatic apply_reset();
        wr_en     = 1'b0;
        dbg_halt  = 1'b0;
        rst_ext_n = 1'b0;
        tick(2);
        rst_ext_n = 1'b1;
        tick(1);
    endtask

    task automatic cfg(input logic [31:0] load, input logic [31:0] ctrl);
        wr(2'd3, UNLK);
        wr(2'd1, load);
        wr(2'd3, UNLK);
        wr(2'd0, ctrl);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (cnt_val !== 24'hFFFFFF) begin errors++; $display("FAIL reset_cnt cnt_val=0x%06h expected 0xffffff", cnt_val); end
        checks++; if (wdg_irq !== 1'b0) begin errors++; $display("FAIL reset_irq wdg_irq=%0b expected 0", wdg_irq); end
        checks++; if (reset_wdg !== 1'b0) begin errors++; $display("FAIL reset_rst reset_wdg=%0b expected 0", reset_wdg); end
        checks++; if (wdg_sts !== 2'b00) begin errors++; $display("FAIL reset_sts wdg_sts=%02b expected 00", wdg_sts); end
        // Locked writes must not start the timer nor change LOAD
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd10);
        tick(5);
        checks++; if (cnt_val !== 24'hFFFFFF) begin errors++; $display("FAIL lock_cnt cnt_val=0x%06h expected 0xffffff", cnt_val); end
        wr(2'd3, BAD);
        checks++; if (wdg_sts !== 2'b10) begin errors++; $display("FAIL badkey_idle_sts wdg_sts=%02b expected 10", wdg_sts); end
        checks++; if (wdg_irq !== 1'b0) begin errors++; $display("FAIL badkey_idle_irq wdg_irq=%0b expected 0", wdg_irq); end
    endtask

    task automatic test_expiry();
        int n;
        apply_reset();
        cfg(32'd10, 32'd3);
        tick(1);
        checks++; if (cnt_val !== 24'd10) begin errors++; $display("FAIL run_entry cnt_val=%0d expected 10", cnt_val); end
        tick(10);
        checks++; if (cnt_val !== 24'd0 || wdg_irq !== 1'b0) begin errors++; $display("FAIL pre_expiry cnt_val=%0d irq=%0b expected 0/0", cnt_val, wdg_irq); end
        tick(1);
        $display("expiry1 cnt=%0d irq=%0b sts=%02b", cnt_val, wdg_irq, wdg_sts);
        checks++; if (wdg_irq !== 1'b1 || cnt_val !== 24'd10) begin errors++; $display("FAIL expiry1 irq=%0b cnt_val=%0d expected 1/10", wdg_irq, cnt_val); end
        checks++; if (wdg_sts !== 2'b01) begin errors++; $display("FAIL expiry1_sts wdg_sts=%02b expected 01", wdg_sts); end
        tick(10);
        checks++; if (cnt_val !== 24'd0 || reset_wdg !== 1'b0) begin errors++; $display("FAIL pre_expiry2 cnt_val=%0d rst=%0b expected 0/0", cnt_val, reset_wdg); end
        tick(1);
        n = 0;
        while (reset_wdg === 1'b1 && n < 20) begin
            n++;
            tick(1);
        end
        $display("expiry2 pulse_len=%0d", n);
        checks++; if (n !== 4) begin errors++; $display("FAIL pulse_len got=%0d expected 4", n); end
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10) begin errors++; $display("FAIL post_pulse irq=%0b cnt_val=%0d expected 0/10", wdg_irq, cnt_val); end
        tick(1);
        checks++; if (cnt_val !== 24'd9) begin errors++; $display("FAIL post_pulse_run cnt_val=%0d expected 9", cnt_val); end
    endtask

    task automatic test_kick();
        bit seen;
        int n;
        apply_reset();
        cfg(32'd10, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 8 == 0) begin
                wr_en   = 1'b1;
                wr_addr = 2'd3;
                wr_data = KICK;
            end else begin
                wr_en = 1'b0;
            end
            tick(1);
            if (wdg_irq === 1'b1 || reset_wdg === 1'b1) seen = 1'b1;
        end
        wr_en = 1'b0;
        $display("kick_loop 1000 cycles seen_irq_or_rst=%0b", seen);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kick_loop irq/reset seen=%0b expected 0", seen); end
        wr(2'd3, KICK);
        checks++; if (cnt_val !== 24'd10) begin errors++; $display("FAIL kick_reload cnt_val=%0d expected 10", cnt_val); end
        tick(1);
        checks++; if (cnt_val !== 24'd9) begin errors++; $display("FAIL kick_dec cnt_val=%0d expected 9", cnt_val); end
        n = 0;
        while (wdg_irq !== 1'b1 && n < 30) begin
            n++;
            tick(1);
        end
        checks++; if (wdg_irq !== 1'b1) begin errors++; $display("FAIL irq_wait wdg_irq=%0b expected 1 within 30 cycles", wdg_irq); end
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10) begin errors++; $display("FAIL kick_in_irq irq=%0b cnt_val=%0d expected 0/10", wdg_irq, cnt_val); end
    endtask

    task automatic test_bad_key();
        int n;
        bit seen;
        apply_reset();
        cfg(32'd10, 32'd3);
        tick(3);
        wr(2'd3, BAD);
        checks++; if (wdg_irq !== 1'b1 || wdg_sts !== 2'b10) begin errors++; $display("FAIL bad1 irq=%0b sts=%02b expected 1/10", wdg_irq, wdg_sts); end
        wr(2'd3, BAD);
        n = 0;
        while (reset_wdg === 1'b1 && n < 20) begin
            n++;
            tick(1);
        end
        $display("bad2 rst_en=1 pulse_len=%0d", n);
        checks++; if (n !== 4) begin errors++; $display("FAIL bad2_pulse got=%0d expected 4", n); end

        apply_reset();
        cfg(32'd10, 32'd1);
        tick(3);
        wr(2'd3, BAD);
        checks++; if (wdg_irq !== 1'b1) begin errors++; $display("FAIL bad1_norst irq=%0b expected 1", wdg_irq); end
        wr(2'd3, BAD);
        seen = reset_wdg;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (reset_wdg === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || wdg_irq !== 1'b1) begin errors++; $display("FAIL bad2_norst rst_seen=%0b irq=%0b expected 0/1", seen, wdg_irq); end
        wr(2'd3, UNLK);
        wr(2'd0, 32'd1);
        checks++; if (wdg_sts !== 2'b00) begin errors++; $display("FAIL sts_clear wdg_sts=%02b expected 00", wdg_sts); end
    endtask

    task automatic test_halt();
        bit seen;
        apply_reset();
        cfg(32'd10, 32'd1);
        tick(4);
        checks++; if (cnt_val !== 24'd7) begin errors++; $display("FAIL halt_pre cnt_val=%0d expected 7", cnt_val); end
        dbg_halt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (cnt_val !== 24'd7 || wdg_irq === 1'b1) seen = 1'b1;
        end
        $display("halt 50 cycles cnt=%0d irq=%0b", cnt_val, wdg_irq);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL halt_frozen cnt_val=%0d irq=%0b expected 7/0 throughout", cnt_val, wdg_irq); end
        dbg_halt = 1'b0;
        tick(7);
        checks++; if (cnt_val !== 24'd0 || wdg_irq !== 1'b0) begin errors++; $display("FAIL halt_resume cnt_val=%0d irq=%0b expected 0/0", cnt_val, wdg_irq); end
        tick(1);
        checks++; if (wdg_irq !== 1'b1) begin errors++; $display("FAIL halt_expiry irq=%0b expected 1", wdg_irq); end
        dbg_halt = 1'b1;
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10) begin errors++; $display("FAIL halt_kick irq=%0b cnt_val=%0d expected 0/10", wdg_irq, cnt_val); end
        tick(3);
        checks++; if (cnt_val !== 24'd10) begin errors++; $display("FAIL halt_kick_hold cnt_val=%0d expected 10", cnt_val); end
        dbg_halt = 1'b0;
    endtask

`ifdef WDG_WINDOW_EN
    task automatic test_window();
        apply_reset();
        wr(2'd3, UNLK);
        wr(2'd2, 32'd4);
        cfg(32'd10, 32'd5);
        tick(4);
        checks++; if (cnt_val !== 24'd7) begin errors++; $display("FAIL win_pre cnt_val=%0d expected 7", cnt_val); end
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b1 || wdg_sts !== 2'b10) begin errors++; $display("FAIL win_early irq=%0b sts=%02b expected 1/10", wdg_irq, wdg_sts); end
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10) begin errors++; $display("FAIL win_irq_kick irq=%0b cnt_val=%0d expected 0/10", wdg_irq, cnt_val); end
        tick(7);
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10) begin errors++; $display("FAIL win_ok irq=%0b cnt_val=%0d expected 0/10", wdg_irq, cnt_val); end
        tick(10);
        checks++; if (cnt_val !== 24'd0) begin errors++; $display("FAIL win_zero cnt_val=%0d expected 0", cnt_val); end
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10) begin errors++; $display("FAIL win_kick_at_zero irq=%0b cnt_val=%0d expected 0/10", wdg_irq, cnt_val); end
    endtask
`else
    task automatic test_nowin();
        apply_reset();
        wr(2'd3, UNLK);
        wr(2'd2, 32'd4);
        wr(2'd1, 32'd5);
        tick(1);
        checks++; if (cnt_val !== 24'd5) begin errors++; $display("FAIL nowin_unlock cnt_val=%0d expected 5", cnt_val); end
        cfg(32'd10, 32'd5);
        tick(4);
        checks++; if (cnt_val !== 24'd7) begin errors++; $display("FAIL nowin_pre cnt_val=%0d expected 7", cnt_val); end
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10 || wdg_sts !== 2'b00) begin errors++; $display("FAIL nowin_kick irq=%0b cnt_val=%0d sts=%02b expected 0/10/00", wdg_irq, cnt_val, wdg_sts); end
        tick(10);
        wr(2'd3, KICK);
        checks++; if (wdg_irq !== 1'b0 || cnt_val !== 24'd10) begin errors++; $display("FAIL nowin_kick_at_zero irq=%0b cnt_val=%0d expected 0/10", wdg_irq, cnt_val); end
    endtask
`endif

    initial begin
        test_reset();
        test_expiry();
        test_kick();
        test_bad_key();
        test_halt();
`ifdef WDG_WINDOW_EN
        test_window();
`else
        test_nowin();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
